// File: rtl/fft_ram_pkg.sv
// Shared definitions for the FFT sample RAM: geometry, complex sample type and
// the word packing (re in the high half, im in the low half) used by both RAM ports.
package fft_ram_pkg;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 16;
  localparam int N_POINTS = 128;
  localparam int WORD_W   = 2 * DATA_W;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  function automatic logic [WORD_W-1:0] pack_word(input cplx_t s);
    return {s.re, s.im};
  endfunction

  function automatic cplx_t unpack_word(input logic [WORD_W-1:0] w);
    cplx_t s;
    s.re = w[WORD_W-1:DATA_W];
    s.im = w[DATA_W-1:0];
    return s;
  endfunction

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_rd_skid.sv
// Two-entry output buffer for RAM read data. The head entry registers drive the
// stream outputs directly and keep their data when the buffer empties.
module fft_rd_skid
  import fft_ram_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  cplx_t      push_data_i,
  input  logic       push_last_i,
  input  logic       pop_i,
  output cplx_t      head_o,
  output logic       head_last_o,
  output logic       head_vld_o,
  output logic [1:0] occ_o
);

  cplx_t      head_q, head_d;
  cplx_t      tail_q, tail_d;
  logic       head_last_q, head_last_d;
  logic       tail_last_q, tail_last_d;
  logic [1:0] occ_q, occ_d;

  // Next-state selection keyed on occupancy and the push/pop pair.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    head_last_d = head_last_q;
    tail_last_d = tail_last_q;
    occ_d       = occ_q;
    case ({occ_q, push_i, pop_i})
      4'b00_10, 4'b00_11: begin
        head_d      = push_data_i;
        head_last_d = push_last_i;
        occ_d       = 2'd1;
      end
      4'b01_10: begin
        tail_d      = push_data_i;
        tail_last_d = push_last_i;
        occ_d       = 2'd2;
      end
      4'b01_11: begin
        head_d      = push_data_i;
        head_last_d = push_last_i;
      end
      4'b01_01: begin
        head_last_d = 1'b0;
        occ_d       = 2'd0;
      end
      4'b10_01: begin
        head_d      = tail_q;
        head_last_d = tail_last_q;
        occ_d       = 2'd1;
      end
      4'b10_11: begin
        head_d      = tail_q;
        head_last_d = tail_last_q;
        tail_d      = push_data_i;
        tail_last_d = push_last_i;
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Buffer state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      head_last_q <= 1'b0;
      tail_last_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      head_last_q <= head_last_d;
      tail_last_q <= tail_last_d;
      occ_q       <= occ_d;
    end
  end

  assign head_o      = head_q;
  assign head_last_o = head_last_q;
  assign head_vld_o  = |occ_q;
  assign occ_o       = occ_q;

endmodule

// File: rtl/fft_read_ram.sv
// Reads one 128-point frame out of the FFT sample RAM (natural or bit-reversed
// order) and streams it as ready/valid complex beats through a 2-entry buffer.
module fft_read_ram
  import fft_ram_pkg::*;
#(
  parameter int BIT_REV = 0
)
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_d,
  output logic [DATA_W-1:0] re_d,
  output logic [DATA_W-1:0] im_d,
  output logic              d_vld,
  input  logic              d_rdy,
  output logic              d_last,
  output logic              busy_out,
  output logic              done_out
);

  rd_state_e         state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              done_q;

  cplx_t             head_s;
  logic              head_last_s;
  logic              head_vld_s;
  logic [1:0]        occ_s;
  logic              pop_s;
  logic [2:0]        committed_s;
  logic              room_s;
  logic              last_rd_s;

  assign pop_s = head_vld_s & d_rdy;

  // A read issued now lands in the buffer next cycle, so it may only go out if
  // whatever is left after this cycle's push/pop still has a free slot.
  assign committed_s = {1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign room_s      = (committed_s < 3'd2);

  assign rd_en     = (state_q == ST_READ) & room_s;
  assign rd_addr   = (BIT_REV != 0) ? bitrev(cnt_q) : cnt_q;
  assign last_rd_s = rd_en & (cnt_q == ADDR_W'(N_POINTS - 1));

  // Frame sequencing, read counter and read-return tracking.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      inflight_q      <= rd_en;
      inflight_last_q <= last_rd_s;
      done_q          <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en_in) begin
            state_q <= ST_READ;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (rd_en) begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end else begin
            cnt_q <= cnt_q;
          end
          if (last_rd_s) begin
            state_q <= ST_DRAIN;
          end else begin
            state_q <= ST_READ;
          end
        end
        ST_DRAIN: begin
          if (pop_s & head_last_s) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  fft_rd_skid u_skid (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .push_i      (inflight_q),
    .push_data_i (unpack_word(rd_d)),
    .push_last_i (inflight_last_q),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .head_last_o (head_last_s),
    .head_vld_o  (head_vld_s),
    .occ_o       (occ_s)
  );

  assign re_d     = head_s.re;
  assign im_d     = head_s.im;
  assign d_vld    = head_vld_s;
  assign d_last   = head_last_s;
  assign busy_out = (state_q != ST_IDLE);
  assign done_out = done_q;

endmodule

// File: tb/tb_fft_read_ram.sv
// Scoreboard bench for fft_read_ram: a natural-order instance exercised through
// several frame scenarios and a bit-reversed instance checked on one frame.
module tb_fft_read_ram;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        en0, en1, d_rdy0, d_rdy1;
  logic        rd_en0, rd_en1;
  logic [6:0]  rd_addr0, rd_addr1;
  logic [31:0] rd_d0 = 32'd0;
  logic [31:0] rd_d1 = 32'd0;
  logic [15:0] re0, im0, re1, im1;
  logic        vld0, vld1, last0, last1, busy0, busy1, done0, done1;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  int issued0 = 0, beats0 = 0, issued1 = 0, beats1 = 0;
  int done_cnt0 = 0, done_cnt1 = 0, done_cyc0 = 0, first_vld0 = 0, last_cyc0 = 0;
  bit seen_vld0 = 1'b0;
  bit rand_rdy = 1'b0;
  int t, t2;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  fft_read_ram #(.BIT_REV(0)) u0 (
    .clk_in(clk_in), .rst_in(rst_in), .en_in(en0), .rd_en(rd_en0), .rd_addr(rd_addr0),
    .rd_d(rd_d0), .re_d(re0), .im_d(im0), .d_vld(vld0), .d_rdy(d_rdy0), .d_last(last0),
    .busy_out(busy0), .done_out(done0)
  );

  fft_read_ram #(.BIT_REV(1)) u1 (
    .clk_in(clk_in), .rst_in(rst_in), .en_in(en1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_d(rd_d1), .re_d(re1), .im_d(im1), .d_vld(vld1), .d_rdy(d_rdy1), .d_last(last1),
    .busy_out(busy1), .done_out(done1)
  );

  function automatic logic [31:0] ram_word(input logic [6:0] a);
    logic [15:0] k;
    k = {9'd0, a};
    return {k, ~k};
  endfunction

  function automatic logic [6:0] rev7(input logic [6:0] n);
    return {n[0], n[1], n[2], n[3], n[4], n[5], n[6]};
  endfunction

  // Synchronous RAM models with one cycle of read latency.
  always @(posedge clk_in) begin
    if (rd_en0) rd_d0 <= ram_word(rd_addr0);
    if (rd_en1) rd_d1 <= ram_word(rd_addr1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Called on the posedge+1 grid; returns with t = edge number that sampled en.
  task automatic start_frame(input bit both, output int t_start);
    logic [6:0] n;
    en0 = 1'b1;
    en1 = both;
    for (int i = 0; i < 128; i++) begin
      n = 7'(i);
      q0.push_back({(i == 127), ram_word(n)});
      if (both) q1.push_back({(i == 127), ram_word(rev7(n))});
    end
    tick();
    t_start = cyc;
    en0 = 1'b0;
    en1 = 1'b0;
    seen_vld0 = 1'b0;
  endtask

  task automatic wait_done0(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt0 < target && n < budget) begin
      tick();
      n++;
    end
    check_eq("done_count0", done_cnt0, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_en"}, rd_en0, 1'b0);
    check_eq({tag, "_rd_addr"}, rd_addr0, 7'd0);
    check_eq({tag, "_re"}, re0, 16'd0);
    check_eq({tag, "_im"}, im0, 16'd0);
    check_eq({tag, "_vld"}, vld0, 1'b0);
    check_eq({tag, "_last"}, last0, 1'b0);
    check_eq({tag, "_busy"}, busy0, 1'b0);
    check_eq({tag, "_done"}, done0, 1'b0);
  endtask

  // Downstream ready: held high, or 50% random when enabled.
  initial begin
    d_rdy0 = 1'b1;
    forever begin
      @(posedge clk_in);
      #1;
      d_rdy0 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor for the natural-order instance.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (rd_en0) begin
        check_eq("rd_addr0", rd_addr0, issued0[6:0]);
        issued0++;
      end
      if (vld0) begin
        check_eq("q0_has_entry", q0.size() != 0, 1'b1);
        if (q0.size() != 0) check_eq("beat0", {last0, re0, im0}, q0[0]);
        if (!seen_vld0) begin
          seen_vld0 = 1'b1;
          first_vld0 = cyc;
        end
        if (d_rdy0) begin
          if (q0.size() != 0) void'(q0.pop_front());
          beats0++;
          if (last0) last_cyc0 = cyc;
        end
      end else begin
        check_eq("idle_last0", last0, 1'b0);
      end
      if (rd_en0) check_eq("rd_bound0", (issued0 - beats0) <= 2, 1'b1);
      if (done0) begin
        done_cnt0++;
        done_cyc0 = cyc;
      end
    end
  end

  // Monitor for the bit-reversed instance.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (rd_en1) begin
        check_eq("rd_addr1", rd_addr1, rev7(issued1[6:0]));
        issued1++;
      end
      if (vld1) begin
        check_eq("q1_has_entry", q1.size() != 0, 1'b1);
        if (q1.size() != 0) check_eq("beat1", {last1, re1, im1}, q1[0]);
        if (d_rdy1) begin
          if (q1.size() != 0) void'(q1.pop_front());
          beats1++;
        end
      end
      if (done1) done_cnt1++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    d_rdy1 = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_reset_outputs("por");
    tick();
    rst_in = 1'b0;

    // Frame 1: both instances, ready held high, exact latency.
    tick();
    start_frame(1'b1, t);
    @(negedge clk_in);
    check_eq("first_rd_en0", rd_en0, 1'b1);
    check_eq("first_rd_addr0", rd_addr0, 7'd0);
    check_eq("busy_start0", busy0, 1'b1);
    check_eq("first_rd_en1", rd_en1, 1'b1);
    check_eq("first_rd_addr1", rd_addr1, 7'd0);
    while (cyc < t + 130) @(negedge clk_in);
    check_eq("done_pulse0", done0, 1'b1);
    check_eq("busy_end0", busy0, 1'b0);
    check_eq("done_pulse1", done1, 1'b1);
    tick();
    check_eq("first_vld_cyc0", first_vld0, t + 2);
    check_eq("last_cyc0", last_cyc0, t + 129);
    check_eq("done_cyc0", done_cyc0, t + 130);
    check_eq("beats1", beats1, 128);
    check_eq("q1_empty", q1.size(), 0);
    check_eq("done_cnt1", done_cnt1, 1);
    wait_done0(1, 10);

    // Frame 2: random backpressure.
    rand_rdy = 1'b1;
    start_frame(1'b0, t);
    wait_done0(2, 2000);
    rand_rdy = 1'b0;
    check_eq("rand_beats0", beats0, 256);
    check_eq("rand_q0_empty", q0.size(), 0);

    // Frame 3: start pulses during READ and DRAIN are ignored.
    tick();
    start_frame(1'b0, t);
    while (cyc < t + 50) tick();
    en0 = 1'b1;
    tick();
    en0 = 1'b0;
    while (cyc < t + 128) tick();
    en0 = 1'b1;
    tick();
    tick();
    en0 = 1'b0;
    wait_done0(3, 500);
    repeat (10) tick();
    @(negedge clk_in);
    check_eq("ign_rd_en0", rd_en0, 1'b0);
    check_eq("ign_busy0", busy0, 1'b0);
    check_eq("ign_done_cnt0", done_cnt0, 3);
    check_eq("ign_beats0", beats0, 384);
    check_eq("ign_q0_empty", q0.size(), 0);

    // Frame 4: reset mid-frame at beat 40, then a fresh frame.
    tick();
    start_frame(1'b0, t);
    while (beats0 < 384 + 40 && cyc < t + 500) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    q0.delete();
    issued0 = 0;
    beats0 = 0;
    @(negedge clk_in);
    check_reset_outputs("midrst");
    tick();
    check_eq("midrst_no_done", done_cnt0, 3);
    start_frame(1'b0, t);
    @(negedge clk_in);
    check_eq("rst_restart_en0", rd_en0, 1'b1);
    check_eq("rst_restart_addr0", rd_addr0, 7'd0);
    tick();
    wait_done0(4, 500);
    check_eq("rst_beats0", beats0, 128);
    check_eq("rst_q0_empty", q0.size(), 0);

    // Frames 5 and 6: second start issued in the done_out cycle.
    tick();
    start_frame(1'b0, t);
    while (cyc < t + 130) tick();
    start_frame(1'b0, t2);
    check_eq("b2b_done_cyc0", done_cyc0, t + 130);
    @(negedge clk_in);
    check_eq("b2b_rd_en0", rd_en0, 1'b1);
    check_eq("b2b_rd_addr0", rd_addr0, 7'd0);
    tick();
    wait_done0(6, 500);
    check_eq("b2b_done2_cyc0", done_cyc0, t2 + 130);
    check_eq("b2b_beats0", beats0, 384);
    check_eq("b2b_q0_empty", q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_read_ram.md
FFT_READ_RAM -- requirements
Module: fft_read_ram

Interface
REQ-001 Parameter BIT_REV, default 0, meaning 1 = issue read addresses in 7-bit bit-reversed order, 0 = natural order.
REQ-002 clk_in  input  1  sole clock; all logic on rising edge.
REQ-003 rst_in  input  1  reset; synchronous, active-high.
REQ-004 en_in  input  1  start pulse; sampled only in IDLE.
REQ-005 rd_en  output  1  RAM read enable.
REQ-006 rd_addr  output  7  RAM read address.
REQ-007 rd_d  input  32  RAM read data, valid exactly 1 cycle after rd_en; [31:16] = re, [15:0] = im.
REQ-008 re_d  output  16  real sample out.
REQ-009 im_d  output  16  imaginary sample out.
REQ-010 d_vld  output  1  sample valid.
REQ-011 d_rdy  input  1  downstream ready; beat transfers when d_vld & d_rdy.
REQ-012 d_last  output  1  high with d_vld on the 128th sample of a frame.
REQ-013 busy_out  output  1  high from start acceptance until last beat transferred.
REQ-014 done_out  output  1  one-cycle pulse the cycle after the last beat transfers.

Function
REQ-015 FSM states IDLE, READ, DRAIN; IDLE->READ on en_in=1; READ->DRAIN after 128th rd_en issued; DRAIN->IDLE on transfer of the beat with d_last.
REQ-016 en_in in READ/DRAIN is ignored, with no effect on counters or outputs.
REQ-017 Read counter counts 0..127 once per frame; rd_addr = counter (BIT_REV=0) or bit-reversed counter (BIT_REV=1); no wrap within a frame.
REQ-018 Output buffer holds 2 entries; rd_en asserted only when (occupancy + in-flight read - pop this cycle) < 2, so no RAM data is ever dropped.
REQ-019 rd_d captured into buffer the cycle after rd_en, unconditionally.
REQ-020 re_d/im_d/d_vld/d_last driven from buffer head registers; values held stable while d_vld=1 and d_rdy=0.
REQ-021 Latency: en_in high at edge T -> rd_en=1, rd_addr=0 at T+1 -> d_vld=1 at T+3.
REQ-022 With d_rdy held 1, 128 beats are contiguous (T+3..T+130), d_last at T+130, done_out at T+131, busy_out low from T+131.
REQ-023 d_rdy low stalls reads after at most 2 buffered entries; throughput returns to 1 beat/cycle the cycle after d_rdy returns high.
REQ-024 Simultaneous push and pop with buffer full: both occur, occupancy unchanged.
REQ-025 en_in high in the same cycle as done_out is accepted (back-to-back frames).
REQ-026 When d_vld=0, re_d/im_d hold last value; d_last=0.

Reset
REQ-027 rst_in=1 at an edge forces: state IDLE, counters 0, buffer empty, in-flight flag 0.
REQ-028 Output reset values: rd_en=0, rd_addr=0, re_d=0, im_d=0, d_vld=0, d_last=0, busy_out=0, done_out=0.
REQ-029 Reset mid-frame aborts the frame; no done_out, next frame restarts at address 0.

Structure
REQ-030 Shared package fft_ram_pkg holds ADDR_W=7, DATA_W=16, N_POINTS=128, typedef cplx_t {re, im}, and the RAM word packing (re high, im low), also used by the write side.
REQ-031 One sub-module fft_rd_skid: 2-entry buffer of cplx_t plus last flag, with push/pop/occupancy.

Verification
REQ-032 RAM preloaded word[k] = {k, ~k}; en_in pulse, d_rdy=1 -> 128 beats re=k, im=~k in order, d_vld first at T+3, d_last at k=127, done_out at T+131.
REQ-033 BIT_REV=1, same RAM -> beat n has re = bitrev7(n); addresses 0,64,32,96,...
REQ-034 d_rdy random 50% -> same 128-beat sequence, no loss/duplication, data stable during stall, rd_en never issued with 2 entries plus in-flight.
REQ-035 en_in pulses during READ and DRAIN -> ignored, exactly one frame, one done_out.
REQ-036 rst_in asserted at beat 40 then en_in -> outputs at reset values next cycle, new frame starts rd_addr=0, full 128 beats.
REQ-037 en_in asserted in the done_out cycle -> second frame rd_en at next cycle, two complete frames, two done_out pulses.
